// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU codes, sequencer state encoding and control vector.
package cpu_pkg;

    localparam int OPC_W_DEF = 5;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_enable;
        logic       pc_increment_enable;
        logic       ir_enable;
        logic       y_enable;
        logic       z_enable;
        logic       mar_enable;
        logic       mdr_enable;
        logic       r_enable;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       baout;
        logic       pc_select;
        logic       z_lo_select;
        logic       mdr_select;
        logic       c_select;
        logic       r_select;
        logic [4:0] alu_instruction;
        logic       run;
    } ctrl_t;

    function automatic logic op_is_reg_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic op_is_imm_alu(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic op_is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic op_known(input logic [4:0] op);
        return op_is_mem(op) || op_is_reg_alu(op) || op_is_imm_alu(op) ||
               (op == OP_NOP) || (op == OP_HALT);
    endfunction

    // Immediate forms share the ALU code of their register counterpart.
    function automatic logic [4:0] alu_code(input logic [4:0] op);
        logic [4:0] code;
        case (op)
            OP_SUB:          code = ALU_SUB;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR,  OP_ORI:  code = ALU_OR;
            default:         code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave), including the IR feedback.
interface control_unit_if;
    logic [31:0] IR_Data;
    logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic        MAR_enable, MDR_enable, r_enable;
    logic        read, write;
    logic        Gra, Grb, Grc, BAout;
    logic        PC_select, Z_LO_select, MDR_select, c_select, r_select;
    logic [4:0]  alu_instruction;
    logic        run;
    logic        illegal;

    modport master (
        input  IR_Data,
        output PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, r_enable, read, write,
               Gra, Grb, Grc, BAout,
               PC_select, Z_LO_select, MDR_select, c_select, r_select,
               alu_instruction, run, illegal
    );

    modport slave (
        output IR_Data,
        input  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, r_enable, read, write,
               Gra, Grb, Grc, BAout,
               PC_select, Z_LO_select, MDR_select, c_select, r_select,
               alu_instruction, run, illegal
    );
endinterface

// File: rtl/control_decode.sv
// Combinational Moore decode of sequencer state plus opcode into the control vector.
module control_decode
    import cpu_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  state_t           state_i,
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o,
    output logic             illegal_o
);

    logic is_mem, is_reg, is_imm, is_ld, is_ldi, is_st, is_bad;

    always_comb begin
        is_mem = op_is_mem(opcode_i);
        is_reg = op_is_reg_alu(opcode_i);
        is_imm = op_is_imm_alu(opcode_i);
        is_ld  = (opcode_i == OP_LD);
        is_ldi = (opcode_i == OP_LDI);
        is_st  = (opcode_i == OP_ST);
        is_bad = !op_known(opcode_i);
    end

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        ctrl_o.run = (state_i != ST_RST) && (state_i != ST_HALT);
        case (state_i)
            ST_T0: begin
                ctrl_o.pc_select  = 1'b1;
                ctrl_o.mar_enable = 1'b1;
            end
            ST_T1: begin
                ctrl_o.pc_increment_enable = 1'b1;
                ctrl_o.read                = 1'b1;
                ctrl_o.mdr_enable          = 1'b1;
            end
            ST_T2: begin
                ctrl_o.mdr_select = 1'b1;
                ctrl_o.ir_enable  = 1'b1;
            end
            ST_T3: begin
                // Base register into Y; memory ops route it through BAout so R0 reads as zero.
                if (is_mem) begin
                    ctrl_o.grb      = 1'b1;
                    ctrl_o.baout    = 1'b1;
                    ctrl_o.y_enable = 1'b1;
                end else if (is_reg || is_imm) begin
                    ctrl_o.grb      = 1'b1;
                    ctrl_o.r_select = 1'b1;
                    ctrl_o.y_enable = 1'b1;
                end
                illegal_o = is_bad;
            end
            ST_T4: begin
                if (is_mem) begin
                    ctrl_o.c_select        = 1'b1;
                    ctrl_o.alu_instruction = ALU_ADD;
                    ctrl_o.z_enable        = 1'b1;
                end else if (is_reg) begin
                    ctrl_o.grc             = 1'b1;
                    ctrl_o.r_select        = 1'b1;
                    ctrl_o.alu_instruction = alu_code(opcode_i);
                    ctrl_o.z_enable        = 1'b1;
                end else if (is_imm) begin
                    ctrl_o.c_select        = 1'b1;
                    ctrl_o.alu_instruction = alu_code(opcode_i);
                    ctrl_o.z_enable        = 1'b1;
                end
            end
            ST_T5: begin
                if (is_ld || is_st) begin
                    ctrl_o.z_lo_select = 1'b1;
                    ctrl_o.mar_enable  = 1'b1;
                end else if (is_ldi || is_reg || is_imm) begin
                    ctrl_o.z_lo_select = 1'b1;
                    ctrl_o.gra         = 1'b1;
                    ctrl_o.r_enable    = 1'b1;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    ctrl_o.read       = 1'b1;
                    ctrl_o.mdr_enable = 1'b1;
                end else if (is_st) begin
                    ctrl_o.gra        = 1'b1;
                    ctrl_o.r_select   = 1'b1;
                    ctrl_o.mdr_enable = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    ctrl_o.mdr_select = 1'b1;
                    ctrl_o.gra        = 1'b1;
                    ctrl_o.r_enable   = 1'b1;
                end else if (is_st) begin
                    ctrl_o.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired Moore sequencer: state register and next-state logic; outputs decoded combinationally.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    control_unit_if.master    bus
);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opcode;
    ctrl_t            ctrl;
    logic             illegal;

    assign opcode = bus.IR_Data[31 -: OPC_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if ((opcode == OP_NOP) || !op_known(opcode)) begin
                    state_d = ST_T0;
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T4:  state_d = ST_T5;
            ST_T5:  state_d = ((opcode == OP_LD) || (opcode == OP_ST)) ? ST_T6 : ST_T0;
            ST_T6:  state_d = ST_T7;
            ST_T7:  state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    control_decode #(.OPC_W(OPC_W)) u_decode (
        .state_i   (state_q),
        .opcode_i  (opcode),
        .ctrl_o    (ctrl),
        .illegal_o (illegal)
    );

    // PC load is reserved for branches and held low; the PC only increments.
    assign bus.PC_enable           = 1'b0;
    assign bus.PC_increment_enable = ctrl.pc_increment_enable;
    assign bus.IR_enable           = ctrl.ir_enable;
    assign bus.Y_enable            = ctrl.y_enable;
    assign bus.Z_enable            = ctrl.z_enable;
    assign bus.MAR_enable          = ctrl.mar_enable;
    assign bus.MDR_enable          = ctrl.mdr_enable;
    assign bus.r_enable            = ctrl.r_enable;
    assign bus.read                = ctrl.read;
    assign bus.write               = ctrl.write;
    assign bus.Gra                 = ctrl.gra;
    assign bus.Grb                 = ctrl.grb;
    assign bus.Grc                 = ctrl.grc;
    assign bus.BAout               = ctrl.baout;
    assign bus.PC_select           = ctrl.pc_select;
    assign bus.Z_LO_select         = ctrl.z_lo_select;
    assign bus.MDR_select          = ctrl.mdr_select;
    assign bus.c_select            = ctrl.c_select;
    assign bus.r_select            = ctrl.r_select;
    assign bus.alu_instruction     = ctrl.alu_instruction;
    assign bus.run                 = ctrl.run;
    assign bus.illegal             = illegal;

endmodule

// File: doc/control_unit.md
# control_unit

Hard-wired Moore control sequencer for the CPU. It sits directly upstream of `datapath` and replaces the hand-written stimulus sequences that currently drive its enable and select inputs. Each instruction is fetched in T0–T2. The block then decodes `IR_Data[31:27]` and steps through the execute states, one state per clock. It produces the same control signal set that `datapath` already consumes, plus `Grc`.

## Interface
Parameters:
- `OPC_W`, default 5: opcode width, taken from `IR_Data[31:27]`.

Ports:
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `IR_Data`  in  32  current IR contents from `datapath`.
- `PC_enable`, `PC_increment_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `r_enable`  out  1 each  register load enables.
- `read`, `write`  out  1 each  memory read/write strobes.
- `Gra`, `Grb`, `Grc`, `BAout`  out  1 each  register select/encode controls.
- `PC_select`, `Z_LO_select`, `MDR_select`, `c_select`, `r_select`  out  1 each  bus source selects. At most one is high in any state.
- `alu_instruction`  out  5  ALU opcode.
- `run`  out  1  1 while sequencing; 0 in HALT.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Opcodes:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110
  - addi=01100, andi=01101, ori=01110
  - nop=11010, halt=11011
- ALU code: for register and immediate ALU ops, `alu_instruction` equals the base op code (add, sub, and, or; addi maps to add, andi to and, ori to or). Address calculation uses ALU_ADD=00011.
- States: RST, T0–T7, HALT.
- RST: all outputs 0, `run`=0.
- Fetch (common to all instructions):
  - T0: `PC_select`, `MAR_enable`.
  - T1: `PC_increment_enable`, `read`, `MDR_enable`.
  - T2: `MDR_select`, `IR_enable`.
- ld:
  - T3: `Grb`, `BAout`, `Y_enable`.
  - T4: `c_select`, alu=ADD, `Z_enable`.
  - T5: `Z_LO_select`, `MAR_enable`.
  - T6: `read`, `MDR_enable`.
  - T7: `MDR_select`, `Gra`, `r_enable`.
  - Then T0.
- ldi: T3 and T4 as for ld; T5: `Z_LO_select`, `Gra`, `r_enable`; then T0.
- st:
  - T3–T5 as for ld.
  - T6: `Gra`, `r_select`, `MDR_enable` with `read`=0, so MDR loads from the bus.
  - T7: `write`.
  - Then T0.
- add/sub/and/or:
  - T3: `Grb`, `r_select`, `Y_enable`.
  - T4: `Grc`, `r_select`, alu code, `Z_enable`.
  - T5: `Z_LO_select`, `Gra`, `r_enable`.
  - Then T0.
- addi/andi/ori:
  - T3: `Grb`, `r_select`, `Y_enable`.
  - T4: `c_select`, alu code, `Z_enable`.
  - T5: as for register ALU ops.
  - Then T0.
- nop: T3 has no outputs asserted; then T0.
- halt: T3 transitions to HALT. HALT holds with all outputs 0 and `run`=0 until reset.
- Illegal opcode: T3 pulses `illegal`, asserts nothing else, then goes to T0.
- `PC_enable` is never asserted by this block (reserved for branches). It is tied to 0.

## Timing
- Each state lasts exactly one clock. Outputs are a combinational decode of the state register plus the opcode, with no output registers.
- Execute-state decode reads `IR_Data` live. IR is loaded on the edge that leaves T2, so the opcode is valid from T3 onward and must not change until the next T2.
- Instruction lengths, counted from T0 entry to the next T0 entry:
  - ld and st: 8 cycles.
  - ldi and ALU ops: 6 cycles.
  - nop and illegal: 4 cycles.
- Reset behaviour:
  - `reset_n`=0 at any edge forces RST, including mid-instruction. Outputs drop to 0 in the cycle after that edge.
  - RST holds while `reset_n`=0.
  - On the first edge with `reset_n`=1, RST moves to T0.
  - HALT is left only via reset.
- Output rules: no state asserts both `read` and `write`. No state asserts more than one bus select.

## Structure
- `cpu_pkg` shared package:
  - opcode localparams;
  - ALU code localparams (ALU_ADD etc.);
  - state encoding as a 4-bit typedef/localparam set (RST=0, T0–T7=1–8, HALT=9).
- One sub-module, `control_decode`: purely combinational. Inputs are state and opcode; outputs are the full control vector and `illegal`.
- `control_unit` holds only the state register and the next-state logic.

## Test plan
- Reset: hold `reset_n`=0 for 3 clocks → all outputs 0, `run`=0; first edge after release enters T0 with `PC_select`=`MAR_enable`=1.
- addi, IR=0x6100_0005 (opcode 01100) → T3 `Grb`/`r_select`/`Y_enable`; T4 `c_select`, alu=00011, `Z_enable`; T5 `Gra`/`r_enable`; T0 after exactly 6 cycles.
- ld, IR=0x0000_0000 → 8-cycle sequence; `read` high only in T1 and T6; T7 shows `MDR_select`+`Gra`+`r_enable`.
- st, opcode 00010 → `write` high only in T7; T6 has `MDR_enable`=1 with `read`=0.
- halt (11011) then drive 5 more clocks → HALT, `run`=0, all controls 0; `reset_n` pulse returns to T0.
- Illegal opcode 11111 → `illegal`=1 for exactly one cycle in T3, next state T0. Also assert reset during ld T5 → RST on the next edge and `MAR_enable` drops.
